// File: rtl/fft_pkg.sv
// Shared FFT types: the delay-commutator state and a complex sample.
package fft_pkg;

  localparam int FFT_DATA_WIDTH = 16;

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } fft_state_t;

  typedef struct packed {
    logic signed [FFT_DATA_WIDTH-1:0] re;
    logic signed [FFT_DATA_WIDTH-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_sample_buffer.sv
// Half-frame sample store: synchronous write, combinational read, no reset.
module fft_sample_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                            clk,
  input  logic                            wr_en,
  input  logic [$clog2(DEPTH)-1:0]        wr_addr,
  input  logic [2*DATA_WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0]        rd_addr,
  output logic [2*DATA_WIDTH-1:0]         rd_data
);

  logic [2*DATA_WIDTH-1:0] mem [DEPTH];

  // Store the first half of the frame; contents are always rewritten before use.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_delay_commutator.sv
// Radix-2 delay commutator: buffers x[0..N/2-1] then emits pairs (x[k], x[k+N/2]).
module fft_delay_commutator
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           sync_clear,
  input  logic                           in_valid,
  input  logic signed [DATA_WIDTH-1:0]   real_in,
  input  logic signed [DATA_WIDTH-1:0]   imag_in,
  output logic                           out_valid,
  output logic signed [DATA_WIDTH-1:0]   real_out0,
  output logic signed [DATA_WIDTH-1:0]   imag_out0,
  output logic signed [DATA_WIDTH-1:0]   real_out1,
  output logic signed [DATA_WIDTH-1:0]   imag_out1,
  output logic [$clog2(DEPTH)-1:0]       pair_idx,
  output logic                           frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FILL_LAST  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(2*DEPTH - 1);

  fft_state_t              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    accept, wr_en, pair_fire;
  logic [AW-1:0]           wr_addr;
  logic [2*DATA_WIDTH-1:0] rd_data;

  assign accept = en & in_valid;
  // A restarted sample is count 0 and always lands in FILL, so it is written.
  assign wr_en     = accept & (sync_clear | (state_q == FILL));
  assign wr_addr   = sync_clear ? '0 : cnt_q[AW-1:0];
  assign pair_fire = accept & ~sync_clear & (state_q == PAIR);

  // State and sample-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state/count: advance only on accepted samples; sync_clear restarts the frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sync_clear) begin
      state_d = FILL;
      cnt_d   = accept ? CW'(1) : '0;
    end else if (accept) begin
      cnt_d = cnt_q + CW'(1);  // natural wrap from 2*DEPTH-1 to 0
      if (state_q == FILL && cnt_q == FILL_LAST)  state_d = PAIR;
      if (state_q == PAIR && cnt_q == FRAME_LAST) state_d = FILL;
    end
  end

  fft_sample_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({real_in, imag_in}),
    .rd_addr (cnt_q[AW-1:0]),
    .rd_data (rd_data)
  );

  // Output pair register: strobes pulse per pair, data and index hold between pairs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      pair_idx   <= '0;
      real_out0  <= '0;
      imag_out0  <= '0;
      real_out1  <= '0;
      imag_out1  <= '0;
    end else begin
      out_valid  <= pair_fire;
      frame_done <= pair_fire & (cnt_q == FRAME_LAST);
      if (pair_fire) begin
        pair_idx  <= cnt_q[AW-1:0];
        real_out0 <= $signed(rd_data[2*DATA_WIDTH-1:DATA_WIDTH]);
        imag_out0 <= $signed(rd_data[DATA_WIDTH-1:0]);
        real_out1 <= real_in;
        imag_out1 <= imag_in;
      end
    end
  end

endmodule

// File: doc/fft_delay_commutator.md
FFT_DELAY_COMMUTATOR -- requirements
Module: fft_delay_commutator

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the signed width of each real/imag sample.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the half-frame size N/2; legal values are powers of two >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: global stage enable.
REQ-006 The block SHALL have port sync_clear, input, 1 bit: synchronous frame restart.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the input sample is present this cycle.
REQ-008 The block SHALL have ports real_in and imag_in, input, DATA_WIDTH signed each: the streaming input sample.
REQ-009 The block SHALL have port out_valid, input-independent registered output, 1 bit: the output pair is valid.
REQ-010 The block SHALL have ports real_out0, imag_out0, real_out1 and imag_out1, output, DATA_WIDTH signed each: the pair x[k], x[k+DEPTH], driven to the butterfly in0 and in1 ports respectively.
REQ-011 The block SHALL have port pair_idx, output, log2(DEPTH) bits: the k value of the current pair, used for twiddle selection.
REQ-012 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse coincident with the last pair of a frame.

Function
REQ-013 A sample SHALL be accepted only when en=1 and in_valid=1.
REQ-014 The block SHALL keep a sample counter cnt of width log2(DEPTH)+1, advanced by 1 per accepted sample and wrapping from 2*DEPTH-1 to 0.
REQ-015 The block SHALL be a two-state FSM: FILL when cnt < DEPTH, and PAIR when cnt >= DEPTH.
- FILL -> PAIR when the sample at cnt=DEPTH-1 is accepted.
- PAIR -> FILL when the sample at cnt=2*DEPTH-1 is accepted.
REQ-016 In FILL, each accepted sample SHALL be written to buffer[cnt], a DEPTH-entry complex register array; out_valid SHALL be 0 on the next cycle.
REQ-017 In PAIR, each accepted sample at count c SHALL produce, one cycle later (latency exactly 1):
- out0 = buffer[c-DEPTH]
- out1 = the accepted sample
- pair_idx = c-DEPTH
- out_valid = 1
REQ-018 frame_done SHALL be 1 in the same cycle as the out_valid produced by c = 2*DEPTH-1, and 0 otherwise.
REQ-019 On any cycle with no accepted sample (en=0 or in_valid=0), out_valid and frame_done SHALL be 0 next cycle; data outputs and pair_idx SHALL hold their last values; cnt and the buffer SHALL not change.
REQ-020 sync_clear=1 SHALL force cnt to 0 and the state to FILL.
- If a sample is accepted in the same cycle, it SHALL be treated as count 0 and written to buffer[0].
- sync_clear SHALL not clear the buffer or the outputs.
- out_valid SHALL be 0 next cycle.
REQ-021 Data SHALL pass bit-exact: no arithmetic, rounding or sign change is applied to samples.
REQ-022 Input gaps SHALL be tolerated in any position; pairing SHALL depend only on the accepted-sample count.

Reset
REQ-023 While rst=1, cnt, state, out_valid, frame_done, pair_idx and all data outputs SHALL be 0, and the FSM SHALL be in FILL.
REQ-024 Buffer contents SHALL not be reset, but they SHALL never reach an output before being rewritten in FILL.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; the first accepted sample after deassertion SHALL be count 0.

Structure
REQ-026 The FSM state enum and a complex-sample struct of {real, imag}, both DATA_WIDTH signed, SHALL live in the shared package fft_pkg, alongside the other FFT stages.
REQ-027 The buffer SHALL be a single sub-module, fft_sample_buffer: DEPTH entries, synchronous write, combinational read, no reset.

Verification
REQ-028 The bench SHALL cover the following directed scenarios with DEPTH=4:
- Continuous frame: inputs real 1..8, imag -1..-8, en=1 -> on the 4 cycles after samples 5..8, pairs (1,5), (2,6), (3,7), (4,8), pair_idx 0..3, and frame_done only on (4,8).
- Back-to-back frames: two 8-sample frames with no gap -> 8 consecutive pairs, and frame_done pulses exactly twice.
- Gaps: in_valid toggled 1,0,1,0... over the 8-sample frame -> the same four pairs; out_valid is 0 on the cycle after each gap.
- en stall: en=0 for 3 cycles mid-PAIR -> outputs hold, out_valid=0, and pairing resumes with the correct pair_idx.
- sync_clear: asserted with sample 6 of a frame, then 7 more samples -> sample 6 becomes count 0, and the pairs reflect the new alignment.
- Reset mid-PAIR: rst pulsed after sample 5 -> all outputs 0; a fresh 8-sample frame then yields correct pairs with no stale data.
- Extremes: samples at -32768 and 32767 -> passed bit-exact.
